// File: rtl/ir_pkg.sv
// Shared definitions for the IR link controller: NEC frame byte offsets,
// TX sequencer state encoding and the auto-sweep reset pattern.
package ir_pkg;

    // MSB position of each byte inside a decoded 32-bit NEC burst
    localparam int NEC_ADDR_MSB  = 31;
    localparam int NEC_NADDR_MSB = 23;
    localparam int NEC_CMD_MSB   = 15;
    localparam int NEC_NCMD_MSB  = 7;

    // Cycles the transmitter gets to raise tx_busy after a launch
    localparam int BUSY_TIMEOUT = 4;

    // First command of the walking-one sweep
    localparam logic [7:0] SWEEP_RST = 8'h01;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_LAUNCH,
        TX_WAIT_BUSY,
        TX_WAIT_DONE,
        TX_GAP
    } tx_state_t;

    // A frame is well formed when both check bytes are exact inverses
    function automatic logic nec_ok(input logic [31:0] b);
        return (b[NEC_ADDR_MSB -: 8] == ~b[NEC_NADDR_MSB -: 8]) &&
               (b[NEC_CMD_MSB  -: 8] == ~b[NEC_NCMD_MSB  -: 8]);
    endfunction

endpackage

// File: rtl/ir_fifo.sv
// Synchronous first-word-fall-through FIFO. The head word is visible on
// dout whenever empty is low. A push into a full FIFO is accepted only
// when a pop frees a slot in the same cycle.
module ir_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Pointer update; the extra MSB tells full from empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; empty masks stale contents
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ir_link_ctrl.sv
// IR link controller: validates and filters decoded NEC frames into an RX
// FIFO, and sequences queued TX commands to the IR transmitter with a
// minimum idle gap between frames.
// Optional feature: define IR_AUTO_SWEEP_EN to launch a walking-one sweep
// command whenever the TX queue has been empty and idle for GAP_CYCLES.
module ir_link_ctrl
    import ir_pkg::*;
#(
    parameter int         RX_DEPTH   = 4,
    parameter int         TX_DEPTH   = 4,
    parameter logic [7:0] TX_ADDR    = 8'h10,
    parameter logic [7:0] MY_ADDR    = 8'h10,
    parameter bit         FILTER_EN  = 1'b1,
    parameter int         GAP_CYCLES = 4_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rx_burst,
    input  logic        rx_strobe,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    input  logic        rx_ack,
    input  logic [7:0]  tx_cmd_in,
    input  logic        tx_cmd_valid,
    output logic        tx_cmd_ready,
    output logic [7:0]  tx_addr,
    output logic [7:0]  tx_cmd,
    output logic        tx_send,
    input  logic        tx_busy,
    output logic [7:0]  led,
    output logic [7:0]  err_cnt
);

    localparam int CW = $clog2(GAP_CYCLES + BUSY_TIMEOUT + 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] BUSY_LAST = CW'(BUSY_TIMEOUT - 1);

    // ---------------- RX path ----------------
    logic [7:0] rx_addr_b;
    logic [7:0] rx_cmd_b;
    logic       frame_ok;
    logic       addr_hit;
    logic       rx_push;
    logic       rx_pop;
    logic       rx_full;
    logic       rx_empty;
    logic       rx_drop_ovf;
    logic       rx_accept;
    logic       err_inc;

    assign rx_addr_b   = rx_burst[NEC_ADDR_MSB -: 8];
    assign rx_cmd_b    = rx_burst[NEC_CMD_MSB -: 8];
    assign frame_ok    = nec_ok(rx_burst);
    assign addr_hit    = !FILTER_EN || (rx_addr_b == MY_ADDR);
    assign rx_valid    = !rx_empty;
    assign rx_pop      = rx_ack && rx_valid;
    assign rx_push     = rx_strobe && frame_ok && addr_hit;
    assign rx_drop_ovf = rx_push && rx_full && !rx_pop;
    assign rx_accept   = rx_push && !rx_drop_ovf;
    assign err_inc     = (rx_strobe && !frame_ok) || rx_drop_ovf;

    ir_fifo #(.WIDTH(16), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   ({rx_addr_b, rx_cmd_b}),
        .pop   (rx_pop),
        .dout  (rx_data),
        .empty (rx_empty),
        .full  (rx_full)
    );

    // LED mirrors the last accepted command; errors saturate at 8'hFF
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led     <= '0;
            err_cnt <= '0;
        end else begin
            if (rx_accept) led <= rx_cmd_b;
            if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
        end
    end

    // ---------------- TX path ----------------
    tx_state_t  state, state_n;
    logic [CW-1:0] cnt;
    logic       tx_full;
    logic       tx_empty;
    logic [7:0] tx_head;
    logic       tx_pop;
    logic       tx_load;

    // Ready is held low while reset is asserted
    assign tx_cmd_ready = !tx_full && !rst;

    ir_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_cmd_valid && tx_cmd_ready),
        .din   (tx_cmd_in),
        .pop   (tx_pop),
        .dout  (tx_head),
        .empty (tx_empty),
        .full  (tx_full)
    );

`ifdef IR_AUTO_SWEEP_EN
    logic [7:0] sweep;
    logic       from_q;
    logic       load_sweep;
`endif

    // Next-state and launch decode
    always_comb begin
        state_n = state;
        tx_send = 1'b0;
        tx_pop  = 1'b0;
        tx_load = 1'b0;
`ifdef IR_AUTO_SWEEP_EN
        load_sweep = 1'b0;
`endif
        case (state)
            TX_IDLE: begin
                if (!tx_empty) begin
                    state_n = TX_LAUNCH;
                    tx_load = 1'b1;
                end
`ifdef IR_AUTO_SWEEP_EN
                else if (cnt == GAP_LAST) begin
                    state_n    = TX_LAUNCH;
                    tx_load    = 1'b1;
                    load_sweep = 1'b1;
                end
`endif
            end
            TX_LAUNCH: begin
                tx_send = 1'b1;
`ifdef IR_AUTO_SWEEP_EN
                tx_pop  = from_q;
`else
                tx_pop  = 1'b1;
`endif
                state_n = TX_WAIT_BUSY;
            end
            TX_WAIT_BUSY: begin
                if (tx_busy)               state_n = TX_WAIT_DONE;
                else if (cnt == BUSY_LAST) state_n = TX_GAP;
            end
            TX_WAIT_DONE: begin
                if (!tx_busy) state_n = TX_GAP;
            end
            TX_GAP: begin
                if (cnt == GAP_LAST) state_n = TX_IDLE;
            end
            default: state_n = TX_IDLE;
        endcase
    end

    // State register; cnt counts cycles spent in the current state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= TX_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= (state_n != state) ? '0 : cnt + 1'b1;
        end
    end

    // Frame fields are captured on entry to LAUNCH and held until the next one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_addr <= TX_ADDR;
            tx_cmd  <= '0;
`ifdef IR_AUTO_SWEEP_EN
            sweep   <= SWEEP_RST;
            from_q  <= 1'b0;
`endif
        end else if (tx_load) begin
            tx_addr <= TX_ADDR;
`ifdef IR_AUTO_SWEEP_EN
            tx_cmd  <= load_sweep ? sweep : tx_head;
            from_q  <= !load_sweep;
            if (load_sweep) sweep <= {sweep[6:0], sweep[7]};
`else
            tx_cmd  <= tx_head;
`endif
        end
    end

endmodule

// File: tb/tb_ir_link_ctrl.sv
// Directed bench for ir_link_ctrl: RX validation/filtering/overflow,
// TX sequencing with a modelled transmitter, reset abort and error
// saturation. Builds with or without IR_AUTO_SWEEP_EN.
module tb_ir_link_ctrl;

    localparam int G = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rx_burst;
    logic        rx_strobe;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ack;
    logic [7:0]  tx_cmd_in;
    logic        tx_cmd_valid;
    logic        tx_cmd_ready;
    logic [7:0]  tx_addr;
    logic [7:0]  tx_cmd;
    logic        tx_send;
    logic        tx_busy;
    logic [7:0]  led;
    logic [7:0]  err_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit busy_en = 1'b0;
    int         send_cyc[$];
    logic [7:0] send_cmd[$];

    ir_link_ctrl #(
        .RX_DEPTH(4), .TX_DEPTH(4), .TX_ADDR(8'h10), .MY_ADDR(8'h10),
        .FILTER_EN(1'b1), .GAP_CYCLES(G)
    ) dut (
        .clk(clk), .rst(rst),
        .rx_burst(rx_burst), .rx_strobe(rx_strobe),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
        .tx_cmd_in(tx_cmd_in), .tx_cmd_valid(tx_cmd_valid), .tx_cmd_ready(tx_cmd_ready),
        .tx_addr(tx_addr), .tx_cmd(tx_cmd), .tx_send(tx_send), .tx_busy(tx_busy),
        .led(led), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] nec(input logic [7:0] a, input logic [7:0] c);
        return {a, ~a, c, ~c};
    endfunction

    task automatic rx_frame(input logic [31:0] b, input logic ack);
        rx_burst  = b;
        rx_strobe = 1'b1;
        rx_ack    = ack;
        step();
        rx_strobe = 1'b0;
        rx_ack    = 1'b0;
    endtask

    task automatic tx_push(input logic [7:0] c);
        tx_cmd_in    = c;
        tx_cmd_valid = 1'b1;
        step();
        tx_cmd_valid = 1'b0;
    endtask

    task automatic wait_sends(input int n, input int budget);
        int b = budget;
        while (send_cmd.size() < n && b > 0) begin
            step();
            b--;
        end
        chk("tx_send_count", send_cmd.size(), n);
    endtask

    // Record every launch pulse with its cycle and command
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tx_send === 1'b1) begin
                send_cyc.push_back(cyc);
                send_cmd.push_back(tx_cmd);
            end
        end
    end

    // Transmitter model: busy rises 2 cycles after a launch, lasts 100 cycles
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (busy_en && tx_send === 1'b1) begin
                step(2);
                tx_busy = 1'b1;
                step(100);
                tx_busy = 1'b0;
            end
        end
    end

    initial begin
        logic [15:0] drain [4];
        logic [7:0]  e;
        int          sp;
        drain = '{16'h1002, 16'h1003, 16'h1004, 16'h1006};

        rst = 1'b1; rx_burst = '0; rx_strobe = 1'b0; rx_ack = 1'b0;
        tx_cmd_in = '0; tx_cmd_valid = 1'b0;
        step(3);
        chk("rst_ready", tx_cmd_ready, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_tx_send", tx_send, 0);
        chk("rst_tx_addr", tx_addr, 8'h10);
        chk("rst_tx_cmd", tx_cmd, 0);
        chk("rst_led", led, 0);
        chk("rst_err", err_cnt, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", tx_cmd_ready, 1);

        // Good frame lands one cycle after the strobe
        rx_frame(32'h10EF_20DF, 1'b0);
        chk("rx_valid_1", rx_valid, 1);
        chk("rx_data_1", rx_data, 16'h1020);
        chk("led_1", led, 8'h20);
        chk("err_1", err_cnt, 0);
        rx_ack = 1'b1; step(); rx_ack = 1'b0;
        chk("rx_pop_empty", rx_valid, 0);

        // Bad check byte counts an error; wrong address is silent
        rx_frame(32'h10EF_20DE, 1'b0);
        chk("bad_err", err_cnt, 1);
        chk("bad_rx_valid", rx_valid, 0);
        rx_frame(nec(8'h11, 8'h33), 1'b0);
        chk("filt_err", err_cnt, 1);
        chk("filt_rx_valid", rx_valid, 0);
        chk("filt_led", led, 8'h20);

        // Overflow: fifth frame into a depth-4 FIFO is dropped
        for (int i = 1; i <= 5; i++) rx_frame(nec(8'h10, 8'(i)), 1'b0);
        chk("ovf_err", err_cnt, 2);
        chk("ovf_head", rx_data, 16'h1001);
        chk("ovf_led", led, 8'h04);
        // Push into full FIFO with a same-cycle pop succeeds
        rx_frame(nec(8'h10, 8'h06), 1'b1);
        chk("ovf_pop_err", err_cnt, 2);
        chk("ovf_pop_led", led, 8'h06);
        for (int i = 0; i < 4; i++) begin
            chk("drain", rx_data, drain[i]);
            rx_ack = 1'b1; step(); rx_ack = 1'b0;
        end
        chk("drain_empty", rx_valid, 0);

`ifndef IR_AUTO_SWEEP_EN
        // No busy response: LAUNCH, 4 wait cycles, GAP, IDLE, next LAUNCH
        busy_en = 1'b0;
        tx_push(8'hC3);
        tx_push(8'hC4);
        wait_sends(2, 200);
        if (send_cmd.size() >= 2) begin
            chk("to_cmd0", send_cmd[0], 8'hC3);
            chk("to_cmd1", send_cmd[1], 8'hC4);
            chk("to_spacing", send_cyc[1] - send_cyc[0], G + 6);
        end
        chk("tx_addr", tx_addr, 8'h10);
        step(40);
        send_cyc.delete(); send_cmd.delete();

        // Busy for 100 cycles: spacing 2 + 100 + 1 + G + 1
        busy_en = 1'b1;
        tx_push(8'hA1);
        tx_push(8'hB2);
        wait_sends(2, 600);
        if (send_cmd.size() >= 2) begin
            sp = send_cyc[1] - send_cyc[0];
            chk("busy_cmd0", send_cmd[0], 8'hA1);
            chk("busy_cmd1", send_cmd[1], 8'hB2);
            chk("busy_spacing_min", 32'(sp >= 100 + G), 1);
            chk("busy_spacing", sp, 124);
        end
        step(10);
        // Fill queue while transmitter is busy, then reset mid-frame
        for (int i = 0; i < 4; i++) tx_push(8'hD0 + 8'(i));
        chk("tx_full_ready", tx_cmd_ready, 0);
        chk("tx_cmd_hold", tx_cmd, 8'hB2);
        rst = 1'b1;
        step(2);
        chk("rst2_tx_cmd", tx_cmd, 0);
        rst = 1'b0;
        #1;
        chk("rst2_ready", tx_cmd_ready, 1);
        send_cyc.delete(); send_cmd.delete();
        step(200);
        chk("rst2_no_send", send_cmd.size(), 0);
`else
        // Empty queue: walking-one sweep after each idle gap
        busy_en = 1'b0;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        send_cyc.delete(); send_cmd.delete();
        wait_sends(9, 45 * 9 + 100);
        e = 8'h01;
        for (int i = 0; i < 9; i++) begin
            if (i < send_cmd.size()) chk("sweep_cmd", send_cmd[i], e);
            e = {e[6:0], e[7]};
        end
`endif

        // Error counter saturates
        for (int i = 0; i < 260; i++) rx_frame(32'h10EF_20DE, 1'b0);
        chk("err_sat", err_cnt, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Absolute time bound
    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ir_link_ctrl.md
IR_LINK_CTRL -- requirements
Module: ir_link_ctrl

Interface
REQ-001 SHALL have parameter RX_DEPTH, default 4, RX frame FIFO depth (power of 2, >=2).
REQ-002 SHALL have parameter TX_DEPTH, default 4, TX command queue depth (power of 2, >=2).
REQ-003 SHALL have parameter TX_ADDR, default 8'h10, address byte sent with every TX frame.
REQ-004 SHALL have parameter MY_ADDR, default 8'h10, RX address accepted when filtering.
REQ-005 SHALL have parameter FILTER_EN, default 1, 1 = drop RX frames whose addr != MY_ADDR.
REQ-006 SHALL have parameter GAP_CYCLES, default 4_000_000, minimum idle gap between TX frames.
REQ-007 SHALL have ports: clk in 1 (single clock); rst in 1 (asynchronous, active-high reset).
REQ-008 SHALL have ports: rx_burst in 32 (decoded NEC frame); rx_strobe in 1 (1-cycle frame-valid pulse).
REQ-009 SHALL have ports: rx_data out 16 ({addr,cmd}); rx_valid out 1; rx_ack in 1 (pop when rx_valid).
REQ-010 SHALL have ports: tx_cmd_in in 8; tx_cmd_valid in 1; tx_cmd_ready out 1.
REQ-011 SHALL have ports: tx_addr out 8; tx_cmd out 8; tx_send out 1 (1-cycle launch pulse); tx_busy in 1 (transmitter active).
REQ-012 SHALL have ports: led out 8 (last accepted RX cmd); err_cnt out 8 (saturating RX error/overflow count).

Function
REQ-013 rx_burst layout SHALL be [31:24] addr, [23:16] ~addr, [15:8] cmd, [7:0] ~cmd.
REQ-014 On rx_strobe, frame SHALL be valid only if both inverse bytes match; invalid -> dropped, err_cnt+1.
REQ-015 If FILTER_EN=1 and addr != MY_ADDR, frame SHALL be silently dropped (no err_cnt change).
REQ-016 Accepted frame SHALL be pushed as {addr,cmd} and led SHALL take cmd the cycle after rx_strobe.
REQ-017 RX FIFO SHALL be first-word-fall-through; rx_valid asserted one cycle after push into empty FIFO.
REQ-018 Push to full RX FIFO SHALL drop frame and increment err_cnt, unless rx_ack pops that same cycle, in which case the push SHALL succeed.
REQ-019 err_cnt SHALL saturate at 8'hFF.
REQ-020 tx_cmd_ready SHALL equal !tx_full; push only on tx_cmd_valid && tx_cmd_ready.
REQ-021 TX FSM states SHALL be IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP.
REQ-022 IDLE->LAUNCH when TX queue non-empty; LAUNCH pops queue, drives tx_addr=TX_ADDR, tx_cmd=head, tx_send=1 for exactly one cycle, goes to WAIT_BUSY.
REQ-023 WAIT_BUSY->WAIT_DONE when tx_busy=1; if tx_busy not seen within 4 cycles, SHALL go to GAP.
REQ-024 WAIT_DONE->GAP when tx_busy=0; GAP counts GAP_CYCLES cycles then returns to IDLE.
REQ-025 tx_addr/tx_cmd SHALL hold their values from LAUNCH until next LAUNCH.

Reset
REQ-026 On rst: both FIFOs empty, FSM IDLE, rx_valid=0, tx_send=0, tx_cmd_ready=0 during reset and 1 on first cycle after, tx_addr=TX_ADDR, tx_cmd=0, led=0, err_cnt=0, sweep value 8'h01.
REQ-027 rst mid-frame SHALL abort TX FSM immediately; no further tx_send until queue refilled.

Configuration
REQ-028 Macro IR_AUTO_SWEEP_EN defined: when queue empty and FSM IDLE for GAP_CYCLES, SHALL launch sweep cmd (walking one 01->02->...->80->01) instead of a queued cmd; queued cmds SHALL take priority.
REQ-029 IR_AUTO_SWEEP_EN undefined: no sweep logic; TX only from queue.

Structure
REQ-030 Package ir_pkg SHALL hold NEC byte offsets, TX FSM state enum, sweep reset constant.
REQ-031 One parametrised sub-module ir_fifo (sync FWFT FIFO, WIDTH/DEPTH) SHALL be instantiated for RX (16b) and TX (8b).

Verification
REQ-032 rx_burst=32'h10EF_20DF strobe -> rx_data=16'h1020, rx_valid next cycle, led=8'h20.
REQ-033 rx_burst=32'h10EF_20DE -> dropped, err_cnt=1; addr 8'h11 valid frame with FILTER_EN=1 -> dropped, err_cnt unchanged.
REQ-034 RX_DEPTH+1 valid frames, no rx_ack -> last dropped, err_cnt=1; repeat with rx_ack same cycle -> accepted.
REQ-035 Push cmds 8'hA1, 8'hB2; model tx_busy 100 cycles -> two tx_send pulses, tx_cmd A1 then B2, spacing >= 100+GAP_CYCLES.
REQ-036 tx_busy never asserted -> GAP entered 4 cycles after LAUNCH; rst asserted in WAIT_DONE -> IDLE, tx_send stays 0; with IR_AUTO_SWEEP_EN, empty queue -> tx_cmd 01,02,...,80,01.
